// File: rtl/uart_ram_loader.sv
// UART command initiator for RAMIO port A: framed 'W' byte writes and 'R' byte reads.
// Build option LOADER_CHECKSUM_EN: the 'W' ack is the mod-256 payload sum instead of 'K'.
module uart_ram_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_dr,
    output logic                  rx_go,
    output logic [7:0]            tx_data,
    output logic                  tx_go,
    input  logic                  tx_bsy,
    output logic [1:0]            weA,
    output logic [2:0]            reA,
    output logic [ADDR_WIDTH+1:0] addrA,
    output logic [DATA_WIDTH-1:0] dinA,
    input  logic [DATA_WIDTH-1:0] doutA,
    output logic                  busy,
    output logic                  cpu_rst
);
    localparam int AW = ADDR_WIDTH + 2;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;

    typedef enum logic [2:0] {
        IDLE, HDR, WR_BYTE, WR_MEM, RD_REQ, RD_CAP, TX_START, TX_WAIT
    } state_t;

    state_t        r_state, w_state_nxt;
    state_t        r_ret, w_ret_nxt;
    logic          r_is_wr;
    logic [2:0]    r_hdr_idx;
    logic [AW-1:0] r_addr, w_addr_hdr;
    logic [31:0]   r_len, w_len_hdr;
    logic [7:0]    r_byte, r_tx_data, w_tx_nxt, w_ack;
    logic [TW-1:0] r_tmo;
    logic          r_rx_ack, r_busy, w_busy_nxt;
    logic          w_cap, w_tmo, w_tx_load, w_last, w_unused_dout;

    assign w_cap  = rx_dr && rx_go && (r_state == IDLE || r_state == HDR || r_state == WR_BYTE);
    assign w_tmo  = (r_state == HDR || r_state == WR_BYTE) && !w_cap && (r_tmo == TW'(TIMEOUT - 1));
    assign w_last = (r_len == 32'd1);
    assign w_unused_dout = ^doutA[DATA_WIDTH-1:8];

    // Header bytes 0..3 are the address (LE, bits above AW dropped), 4..7 the length.
    always_comb begin
        w_addr_hdr = r_addr;
        w_len_hdr  = r_len;
        for (int b = 0; b < AW; b++)
            if (!r_hdr_idx[2] && (b / 8) == int'(r_hdr_idx[1:0]))
                w_addr_hdr[b] = rx_data[3'(b % 8)];
        if (r_hdr_idx[2])
            w_len_hdr[{r_hdr_idx[1:0], 3'b000} +: 8] = rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_busy_nxt  = r_busy;
        w_tx_load   = 1'b0;
        w_tx_nxt    = r_tx_data;
        case (r_state)
            IDLE: if (w_cap) begin
                if (rx_data == CMD_W || rx_data == CMD_R) begin
                    w_state_nxt = HDR;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = TX_START; w_tx_load = 1'b1; w_tx_nxt = 8'h3F; w_ret_nxt = IDLE;
                end
            end
            HDR: if (w_cap && r_hdr_idx == 3'd7) begin
                if (w_len_hdr != 32'd0)
                    w_state_nxt = r_is_wr ? WR_BYTE : RD_REQ;
                else if (r_is_wr) begin
                    w_state_nxt = TX_START; w_tx_load = 1'b1; w_tx_nxt = w_ack; w_ret_nxt = IDLE;
                end else
                    w_state_nxt = IDLE;
            end else if (w_tmo) begin
                w_state_nxt = TX_START; w_tx_load = 1'b1; w_tx_nxt = 8'h21; w_ret_nxt = IDLE;
            end
            WR_BYTE: if (w_cap) w_state_nxt = WR_MEM;
            else if (w_tmo) begin
                w_state_nxt = TX_START; w_tx_load = 1'b1; w_tx_nxt = 8'h21; w_ret_nxt = IDLE;
            end
            WR_MEM: if (w_last) begin
                w_state_nxt = TX_START; w_tx_load = 1'b1; w_tx_nxt = w_ack; w_ret_nxt = IDLE;
            end else
                w_state_nxt = WR_BYTE;
            RD_REQ: w_state_nxt = RD_CAP;
            RD_CAP: begin
                w_state_nxt = TX_START;
                w_tx_load   = 1'b1;
                w_tx_nxt    = doutA[7:0];
                w_ret_nxt   = w_last ? IDLE : RD_REQ;
            end
            TX_START: if (tx_bsy) w_state_nxt = TX_WAIT;
            TX_WAIT:  if (!tx_bsy) w_state_nxt = r_ret;
            default:  w_state_nxt = IDLE;
        endcase
        if (w_state_nxt == IDLE) w_busy_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ret     <= IDLE;
            r_is_wr   <= 1'b0;
            r_hdr_idx <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_byte    <= '0;
            r_tx_data <= '0;
            r_tmo     <= '0;
            r_rx_ack  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ret    <= w_ret_nxt;
            r_busy   <= w_busy_nxt;
            r_rx_ack <= w_cap;
            if (w_tx_load) r_tx_data <= w_tx_nxt;
            if (w_cap || !(r_state == HDR || r_state == WR_BYTE)) r_tmo <= '0;
            else r_tmo <= r_tmo + 1'b1;
            if (w_cap && r_state == IDLE) begin
                r_hdr_idx <= '0;
                r_is_wr   <= (rx_data == CMD_W);
            end
            if (w_cap && r_state == HDR) begin
                r_hdr_idx <= r_hdr_idx + 1'b1;
                r_addr    <= w_addr_hdr;
                r_len     <= w_len_hdr;
            end
            if (w_cap && r_state == WR_BYTE) r_byte <= rx_data;
            // Address and count advance once the memory cycle for the current byte is done.
            if (r_state == WR_MEM || r_state == RD_CAP) begin
                r_addr <= r_addr + 1'b1;
                r_len  <= r_len - 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    always_ff @(posedge clk) begin
        if (rst)                                r_sum <= '0;
        else if (w_cap && r_state == IDLE)      r_sum <= '0;
        else if (w_cap && r_state == WR_BYTE)   r_sum <= r_sum + rx_data;
    end
    assign w_ack = r_sum;
`else
    assign w_ack = 8'h4B;
`endif

    assign rx_go   = !r_rx_ack;
    assign tx_data = r_tx_data;
    assign tx_go   = (r_state == TX_START) || (r_state == TX_WAIT);
    assign weA     = (r_state == WR_MEM) ? 2'b01 : 2'b00;
    assign reA     = (r_state == RD_REQ) ? 3'b001 : 3'b000;
    assign addrA   = r_addr;
    assign dinA    = {{(DATA_WIDTH-8){1'b0}}, r_byte};
    assign busy    = r_busy;
    assign cpu_rst = r_busy;
endmodule

// File: tb/tb_uart_ram_loader.sv
// Bench for uart_ram_loader: UART and RAM models around the DUT, a reference byte memory and
// an expected-tx queue popped by the UART TX model whenever the DUT starts a transmission.
module tb_uart_ram_loader;
    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int TMO    = 100;
    localparam int ASPACE = 1 << (AW + 2);
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_dr, rx_go;
    logic [7:0]    tx_data;
    logic          tx_go, tx_bsy;
    logic [1:0]    weA;
    logic [2:0]    reA;
    logic [AW+1:0] addrA;
    logic [DW-1:0] dinA, doutA;
    logic          busy, cpu_rst;

    uart_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dr(rx_dr), .rx_go(rx_go),
        .tx_data(tx_data), .tx_go(tx_go), .tx_bsy(tx_bsy), .weA(weA), .reA(reA),
        .addrA(addrA), .dinA(dinA), .doutA(doutA), .busy(busy), .cpu_rst(cpu_rst)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] ram[int];
    logic [7:0] ref_mem[int];
    int we_cnt = 0, re_cnt = 0, clash = 0, bad_en = 0, busy_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ram_rd(input int a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int wrap(input int unsigned a, input int i);
        return int'((a + 32'(i)) % 32'(ASPACE));
    endfunction

    // RAMIO port A: writes on weA, read data presented in the cycle after reA (garbage otherwise).
    initial begin : ram_model
        logic rd_pend;
        int   rd_a;
        rd_pend = 1'b0;
        rd_a    = 0;
        doutA   = '0;
        forever begin
            @(negedge clk);
            if (weA != 2'b00 && reA != 3'b000) clash++;
            if (!(weA inside {2'b00, 2'b01}) || !(reA inside {3'b000, 3'b001})) bad_en++;
            if (weA == 2'b01 && dinA[DW-1:8] != '0) bad_en++;
            if (busy) busy_seen++;
            doutA = DW'($urandom());
            if (rd_pend) doutA[7:0] = ram_rd(rd_a);
            rd_pend = 1'b0;
            if (weA == 2'b01) begin ram[int'(addrA)] = dinA[7:0]; we_cnt++; end
            if (reA == 3'b001) begin rd_pend = 1'b1; rd_a = int'(addrA); re_cnt++; end
        end
    end

    // UartTx model and scoreboard monitor.
    initial begin : tx_model
        logic [7:0] tb_b;
        int n;
        tx_bsy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_go === 1'b1) begin
                tb_b = tx_data;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL tx_unexpected: got %02h, expected no byte", tb_b);
                end else
                    chk("tx_byte", 64'(tb_b), 64'(exp_q.pop_front()));
                tx_bsy = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                tx_bsy = 1'b0;
                n = 0;
                do begin @(negedge clk); n++; end while (tx_go && n < 8);
                chk("tx_go_drop", 64'(tx_go), 64'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_data = b;
        rx_dr   = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (rx_go && n < 200);
        if (rx_go) begin
            n_cmp++; n_err++;
            $display("FAIL rx_capture: byte %02h not taken after %0d cycles", b, n);
        end
        rx_dr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input int unsigned a, input int unsigned len);
        send_byte(cmd);
        chk("busy_rise", 64'({busy, cpu_rst}), 64'b11);
        for (int i = 0; i < 4; i++) send_byte(8'(a >> (8 * i)));
        for (int i = 0; i < 4; i++) send_byte(8'(len >> (8 * i)));
        while (pay_q.size() > 0) send_byte(pay_q.pop_front());
    endtask

    // Reference: payload bytes land at consecutive wrapped addresses; a short payload means timeout.
    task automatic model_write(input int unsigned a, input int unsigned len);
        logic [7:0] sum = 8'h00;
        foreach (pay_q[i]) begin
            ref_mem[wrap(a, i)] = pay_q[i];
            sum += pay_q[i];
        end
        if (pay_q.size() == int'(len)) exp_q.push_back(CHK ? sum : 8'h4B);
        else                           exp_q.push_back(8'h21);
    endtask

    task automatic model_read(input int unsigned a, input int unsigned len);
        for (int i = 0; i < int'(len); i++) exp_q.push_back(ref_rd(wrap(a, i)));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || tx_go || tx_bsy) && n < 3000) begin
            @(negedge clk); n++;
        end
        chk({name, "_idle"}, 64'({exp_q.size() == 0, busy, tx_go}), 64'b100);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_rx_go"},   64'(rx_go),   64'd1);
        chk({name, "_tx_go"},   64'(tx_go),   64'd0);
        chk({name, "_tx_data"}, 64'(tx_data), 64'd0);
        chk({name, "_weA"},     64'(weA),     64'd0);
        chk({name, "_reA"},     64'(reA),     64'd0);
        chk({name, "_addrA"},   64'(addrA),   64'd0);
        chk({name, "_dinA"},    64'(dinA),    64'd0);
        chk({name, "_busy"},    64'({busy, cpu_rst}), 64'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int we0, re0, bs0;
        rst = 1'b1; rx_dr = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Three-byte write at 0x100.
        we0 = we_cnt;
        pay_q = '{8'hAA, 8'hBB, 8'hCC};
        model_write(32'h100, 3);
        send_frame(8'h57, 32'h100, 3);
        wait_idle("wr3");
        chk("wr3_we_pulses", 64'(we_cnt - we0), 64'd3);
        for (int i = 0; i < 3; i++) chk("wr3_mem", 64'(ram_rd(32'h100 + i)), 64'(ref_rd(32'h100 + i)));

        // Two-byte read of preloaded 0x200.
        ram[32'h200] = 8'h12; ram[32'h201] = 8'h34;
        ref_mem[32'h200] = 8'h12; ref_mem[32'h201] = 8'h34;
        re0 = re_cnt; we0 = we_cnt;
        model_read(32'h200, 2);
        send_frame(8'h52, 32'h200, 2);
        wait_idle("rd2");
        chk("rd2_cycles", 64'({re_cnt - re0, we_cnt - we0}), {32'd2, 32'd0});

        // Unknown command byte.
        we0 = we_cnt; re0 = re_cnt; bs0 = busy_seen;
        exp_q.push_back(8'h3F);
        send_byte(8'h55);
        wait_idle("badcmd");
        chk("badcmd_busy_cycles", 64'(busy_seen - bs0), 64'd0);
        chk("badcmd_mem_cycles", 64'((we_cnt - we0) + (re_cnt - re0)), 64'd0);

        // Timeout after 1 of 2 payload bytes.
        ram[32'h301] = 8'hE7; ref_mem[32'h301] = 8'hE7;
        pay_q = '{8'h5A};
        model_write(32'h300, 2);
        send_frame(8'h57, 32'h300, 2);
        wait_idle("tmo");
        chk("tmo_first", 64'(ram_rd(32'h300)), 64'(ref_rd(32'h300)));
        chk("tmo_second", 64'(ram_rd(32'h301)), 64'(ref_rd(32'h301)));
        chk("tmo_busy", 64'(busy), 64'd0);

        // Write across the top of the address space.
        ram[0] = 8'h99; ref_mem[0] = 8'h99;
        pay_q = '{8'h11, 8'h22};
        model_write(32'h0003FFFF, 2);
        send_frame(8'h57, 32'h0003FFFF, 2);
        wait_idle("wrap");
        chk("wrap_top", 64'(ram_rd(ASPACE - 1)), 64'(ref_rd(ASPACE - 1)));
        chk("wrap_zero", 64'(ram_rd(0)), 64'(ref_rd(0)));

        // Zero-length frames.
        we0 = we_cnt; re0 = re_cnt;
        pay_q.delete();
        model_write(32'h500, 0);
        send_frame(8'h57, 32'h500, 0);
        wait_idle("wr0");
        send_frame(8'h52, 32'h500, 0);
        wait_idle("rd0");
        chk("len0_mem_cycles", 64'((we_cnt - we0) + (re_cnt - re0)), 64'd0);

        // Reset while waiting for the second payload byte.
        we0 = we_cnt;
        pay_q = '{8'h77};
        ref_mem[32'h400] = 8'h77;
        send_frame(8'h57, 32'h400, 3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_we_pulses", 64'(we_cnt - we0), 64'd1);
        chk("midrst_mem", 64'(ram_rd(32'h400)), 64'(ref_rd(32'h400)));
        pay_q = '{8'h5C, 8'h6D};
        model_write(32'h400, 2);
        send_frame(8'h57, 32'h400, 2);
        wait_idle("postrst");
        chk("postrst_mem", 64'({ram_rd(32'h400), ram_rd(32'h401)}), 64'({ref_rd(32'h400), ref_rd(32'h401)}));

        // Randomized mix of writes, reads and junk commands.
        for (int k = 0; k < 24; k++) begin
            int kind;
            int unsigned a, len;
            logic [7:0] c;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 0) a = 32'h1000 + 32'($urandom_range(0, 47));
            else a = 32'(ASPACE) - 32'd1 - 32'($urandom_range(0, 3));
            a = a | ($urandom() << (AW + 2));
            pay_q.delete();
            if (kind == 0) begin
                do c = 8'($urandom()); while (c == 8'h57 || c == 8'h52);
                exp_q.push_back(8'h3F);
                send_byte(c);
            end else if (kind <= 5) begin
                for (int i = 0; i < int'(len); i++) pay_q.push_back(8'($urandom()));
                model_write(a, len);
                send_frame(8'h57, a, len);
            end else begin
                model_read(a, len);
                send_frame(8'h52, a, len);
            end
            wait_idle("rand");
        end

        chk("we_re_clash", 64'(clash), 64'd0);
        chk("enable_encoding", 64'(bad_en), 64'd0);
        foreach (ref_mem[a]) chk("mem_final", 64'(ram_rd(a)), 64'(ref_mem[a]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
